otter_io_sequencer: RTL

OTTER_IO_SEQUENCER -- requirements
Module: otter_io_sequencer

---
 rtl/otter_io_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/otter_io_sequencer.sv
// otter_io_sequencer: scripted stimulus/response checker for an OTTER I/O board.
// Each script entry drives switches/buttons, waits a programmable number of
// cycles, then compares the observed LEDs against an expected value under a
// per-bit mask. Mismatches are counted (saturating), and the first failing
// index is recorded.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no run since reset; script writable; waiting for start
// S_APPLY | drive entry[idx] stimulus, load the wait timer
// S_WAIT  | settle timer counting down; leave on terminal count of 1
// S_CHECK | compare leds against the expected value of entry[idx]
// S_DONE  | run finished; results held; script writable; start relaunches
module otter_io_sequencer #(
  parameter int SW_W   = 16,
  parameter int BTN_W  = 5,
  parameter int LED_W  = 16,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       num_entries,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [SW_W-1:0]   ld_sw,
  input  logic [BTN_W-1:0]  ld_btn,
  input  logic [LED_W-1:0]  ld_exp,
  input  logic [LED_W-1:0]  ld_mask,
  input  logic [WAIT_W-1:0] ld_wait,
  input  logic [LED_W-1:0]  leds,
  output logic [SW_W-1:0]   switches,
  output logic [BTN_W-1:0]  buttons,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       fail_count,
  output logic [AW-1:0]     fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic [SW_W-1:0]   ent_sw   [DEPTH];
  logic [BTN_W-1:0]  ent_btn  [DEPTH];
  logic [LED_W-1:0]  ent_exp  [DEPTH];
  logic [LED_W-1:0]  ent_mask [DEPTH];
  logic [WAIT_W-1:0] ent_wait [DEPTH];

  logic [AW-1:0]     idx;
  logic [AW:0]       num_reg;
  logic [WAIT_W-1:0] wcnt;

  logic [AW:0] num_clamped;
  logic        mismatch;
  logic        last;
  logic [AW:0] fc_next;

  logic ld_ok, launch, launch_empty, do_apply, do_wait, do_check;

  // Clamp the requested run length so idx can never run past the script.
  always_comb begin
    num_clamped = num_entries;
    if (num_entries > DEPTH_L) num_clamped = DEPTH_L;
  end

  // Entry compare and saturating failure-count update for the CHECK cycle.
  always_comb begin
    mismatch = |((leds ^ ent_exp[idx]) & ent_mask[idx]);
    last     = ({1'b0, idx} == (num_reg - 1'b1));
    fc_next  = fail_count;
    if (mismatch && (fail_count != '1)) fc_next = fail_count + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state datapath strobes.
  always_comb begin
    state_nxt    = state;
    ld_ok        = 1'b0;
    launch       = 1'b0;
    launch_empty = 1'b0;
    do_apply     = 1'b0;
    do_wait      = 1'b0;
    do_check     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        ld_ok = 1'b1;
        if (start) begin
          if (num_clamped == '0) begin
            launch_empty = 1'b1;
            state_nxt    = S_DONE;
          end else begin
            launch    = 1'b1;
            state_nxt = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        do_apply  = 1'b1;
        state_nxt = (ent_wait[idx] != '0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        do_wait = 1'b1;
        // Terminal count of 1 gives exactly N cycles in WAIT for wait=N.
        if (wcnt <= WAIT_W'(1)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        do_check  = 1'b1;
        state_nxt = last ? S_DONE : S_APPLY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);

  // Script storage; writes accepted only while no run is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_sw[i]   <= '0;
        ent_btn[i]  <= '0;
        ent_exp[i]  <= '0;
        ent_mask[i] <= '0;
        ent_wait[i] <= '0;
      end
    end else if (ld_ok && ld_en) begin
      ent_sw[ld_addr]   <= ld_sw;
      ent_btn[ld_addr]  <= ld_btn;
      ent_exp[ld_addr]  <= ld_exp;
      ent_mask[ld_addr] <= ld_mask;
      ent_wait[ld_addr] <= ld_wait;
    end
  end

  // Run datapath: index, timer, stimulus outputs and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      num_reg    <= '0;
      wcnt       <= '0;
      switches   <= '0;
      buttons    <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_idx   <= '0;
    end else begin
      if (launch) begin
        idx        <= '0;
        num_reg    <= num_clamped;
        fail_count <= '0;
        fail_idx   <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
      end
      if (launch_empty) begin
        num_reg    <= '0;
        fail_count <= '0;
        fail_idx   <= '0;
        done       <= 1'b1;
        pass       <= 1'b1;
      end
      if (do_apply) begin
        switches <= ent_sw[idx];
        buttons  <= ent_btn[idx];
        wcnt     <= ent_wait[idx];
      end
      if (do_wait) wcnt <= wcnt - 1'b1;
      if (do_check) begin
        fail_count <= fc_next;
        if (mismatch && (fail_count == '0)) fail_idx <= idx;
        if (last) begin
          done <= 1'b1;
          pass <= (fc_next == '0);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
